// File: rtl/mips_lsu.sv
// mips_lsu: memory-access stage of the MIPS pipeline.
// Takes one decoded load/store and performs it as a single word access on a
// req/ack data-memory port. The stage steers store bytes onto the correct
// lanes, rejects misaligned or illegal sizes, formats load data and aborts
// the access with a bus error if memory never answers. The pipeline is held
// with lsu_stall until the one-cycle lsu_done pulse.
module mips_lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        lsu_valid,
    input  logic        lsu_is_store,
    input  logic [2:0]  lsu_bytes,
    input  logic        lsu_sign_ext,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wdata,
    output logic [31:0] lsu_rdata,
    output logic        lsu_done,
    output logic        lsu_stall,
    output logic        lsu_misaligned,
    output logic        lsu_buserr,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    // The counter only has to reach TIMEOUT_CYCLES-1: the cycle that would
    // take it to TIMEOUT_CYCLES is the one that aborts the access.
    localparam int CNT_W = (TIMEOUT_CYCLES < 3) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Size/alignment legality: byte anywhere, half on even, word on 4-byte.
    function automatic logic access_legal(input logic [2:0] bytes, input logic [1:0] a);
        logic ok;
        case (bytes)
            3'd1:    ok = 1'b1;
            3'd2:    ok = (a[0] == 1'b0);
            3'd4:    ok = (a == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte write enables for a store of the given size at lane offset a.
    function automatic logic [3:0] lane_we(input logic [2:0] bytes, input logic [1:0] a);
        logic [3:0] we;
        case (bytes)
            3'd1:    we = 4'b0001 << a;
            3'd2:    we = 4'b0011 << a;
            default: we = 4'b1111;
        endcase
        return we;
    endfunction

    // Store data replicated across all lanes so the enables pick the right copy.
    function automatic logic [31:0] lane_wdata(input logic [2:0] bytes, input logic [31:0] wd);
        logic [31:0] d;
        case (bytes)
            3'd1:    d = {4{wd[7:0]}};
            3'd2:    d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    // Little-endian extraction of the addressed byte/half plus sign or zero extension.
    function automatic logic [31:0] load_format(input logic [2:0] bytes, input logic sx,
                                                input logic [1:0] a, input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (bytes)
            3'd1:    r = {{24{sx & b[7]}}, b};
            3'd2:    r = {{16{sx & h[15]}}, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             is_store_r, is_store_s;
    logic [2:0]       bytes_r, bytes_s;
    logic             sign_ext_r, sign_ext_s;
    logic [31:0]      addr_r, addr_s;
    logic [31:0]      wdata_r, wdata_s;
    logic             mem_req_r, mem_req_s;
    logic [31:0]      mem_addr_r, mem_addr_s;
    logic [3:0]       mem_we_r, mem_we_s;
    logic [31:0]      mem_wdata_r, mem_wdata_s;
    logic [31:0]      lsu_rdata_r, lsu_rdata_s;
    logic             lsu_done_r, lsu_done_s;
    logic             lsu_mis_r, lsu_mis_s;
    logic             lsu_berr_r, lsu_berr_s;

    // Next-state and next-output computation; every register holds by default
    // and the completion flags default low so they pulse for one cycle only.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        is_store_s  = is_store_r;
        bytes_s     = bytes_r;
        sign_ext_s  = sign_ext_r;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        mem_req_s   = mem_req_r;
        mem_addr_s  = mem_addr_r;
        mem_we_s    = mem_we_r;
        mem_wdata_s = mem_wdata_r;
        lsu_rdata_s = lsu_rdata_r;
        lsu_done_s  = 1'b0;
        lsu_mis_s   = 1'b0;
        lsu_berr_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (lsu_valid) begin
                    is_store_s = lsu_is_store;
                    bytes_s    = lsu_bytes;
                    sign_ext_s = lsu_sign_ext;
                    addr_s     = lsu_addr;
                    wdata_s    = lsu_wdata;
                    if (access_legal(lsu_bytes, lsu_addr[1:0])) begin
                        state_s = ST_ACCESS;
                        cnt_s   = '0;
                    end else begin
                        // Illegal access never reaches memory.
                        state_s    = ST_DONE;
                        lsu_done_s = 1'b1;
                        lsu_mis_s  = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_ACCESS: begin
                if (!mem_req_r) begin
                    // First ACCESS cycle: launch the request from captured fields.
                    mem_req_s  = 1'b1;
                    mem_addr_s = {addr_r[31:2], 2'b00};
                    if (is_store_r) begin
                        mem_we_s    = lane_we(bytes_r, addr_r[1:0]);
                        mem_wdata_s = lane_wdata(bytes_r, wdata_r);
                    end else begin
                        mem_we_s    = 4'b0000;
                        mem_wdata_s = 32'h0000_0000;
                    end
                end else if (mem_ack) begin
                    // Ack is checked before the timeout so it wins a tie.
                    mem_req_s  = 1'b0;
                    mem_we_s   = 4'b0000;
                    state_s    = ST_DONE;
                    lsu_done_s = 1'b1;
                    if (!is_store_r) begin
                        lsu_rdata_s = load_format(bytes_r, sign_ext_r, addr_r[1:0], mem_rdata);
                    end else begin
                        lsu_rdata_s = lsu_rdata_r;
                    end
                end else if (cnt_r == CNT_LAST) begin
                    mem_req_s  = 1'b0;
                    mem_we_s   = 4'b0000;
                    state_s    = ST_DONE;
                    lsu_done_s = 1'b1;
                    lsu_berr_s = 1'b1;
                    cnt_s      = '0;
                end else begin
                    cnt_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end

            ST_DONE: begin
                state_s = ST_IDLE;
            end

            default: begin
                state_s   = ST_IDLE;
                mem_req_s = 1'b0;
                mem_we_s  = 4'b0000;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            is_store_r  <= 1'b0;
            bytes_r     <= 3'd0;
            sign_ext_r  <= 1'b0;
            addr_r      <= 32'h0000_0000;
            wdata_r     <= 32'h0000_0000;
            mem_req_r   <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_we_r    <= 4'b0000;
            mem_wdata_r <= 32'h0000_0000;
            lsu_rdata_r <= 32'h0000_0000;
            lsu_done_r  <= 1'b0;
            lsu_mis_r   <= 1'b0;
            lsu_berr_r  <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            is_store_r  <= is_store_s;
            bytes_r     <= bytes_s;
            sign_ext_r  <= sign_ext_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            mem_req_r   <= mem_req_s;
            mem_addr_r  <= mem_addr_s;
            mem_we_r    <= mem_we_s;
            mem_wdata_r <= mem_wdata_s;
            lsu_rdata_r <= lsu_rdata_s;
            lsu_done_r  <= lsu_done_s;
            lsu_mis_r   <= lsu_mis_s;
            lsu_berr_r  <= lsu_berr_s;
        end
    end

    assign mem_req        = mem_req_r;
    assign mem_addr       = mem_addr_r;
    assign mem_we         = mem_we_r;
    assign mem_wdata      = mem_wdata_r;
    assign lsu_rdata      = lsu_rdata_r;
    assign lsu_done       = lsu_done_r;
    assign lsu_misaligned = lsu_mis_r;
    assign lsu_buserr     = lsu_berr_r;
    assign lsu_stall      = lsu_valid & ~lsu_done_r;

endmodule

// File: doc/mips_lsu.md
Name: mips_lsu

Overview:
- Memory-access stage directly downstream of the instruction decoder and ALU.
- Consumes the decoded load/store controls (access size, sign/zero extension, store flag), the ALU-computed effective address and the rt store data.
- Performs one byte-addressed access over a req/ack data-memory port: byte-lane steering, alignment check, load extraction and extension, and a bus timeout.
- Stalls the pipeline until the access completes.

Parameters:
- TIMEOUT_CYCLES, 255: cycles mem_req may stay high without mem_ack before the access is aborted with a bus error.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_b  in  1  reset; synchronous, active-low
- lsu_valid  in  1  load/store request present; held by pipeline until lsu_done
- lsu_is_store  in  1  1 = store, 0 = load
- lsu_bytes  in  3  access size: 1 = byte, 2 = half, 4 = word
- lsu_sign_ext  in  1  loads: 1 sign-extends, 0 zero-extends (LBU/LHU)
- lsu_addr  in  32  effective byte address
- lsu_wdata  in  32  store data (rt)
- lsu_rdata  out  32  formatted load result
- lsu_done  out  1  one-cycle completion pulse
- lsu_stall  out  1  pipeline hold
- lsu_misaligned  out  1  address/size exception, valid with lsu_done
- lsu_buserr  out  1  timeout exception, valid with lsu_done
- mem_req  out  1  memory request
- mem_addr  out  32  word address {addr[31:2],2'b00}
- mem_we  out  4  byte write enables; 0 for loads
- mem_wdata  out  32  lane-steered store data
- mem_ack  in  1  memory accepted/completed the request
- mem_rdata  in  32  read word, valid when mem_ack=1

Behaviour:
- Reset, synchronous while rst_b=0:
  - State goes to IDLE.
  - All outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, lsu_rdata, lsu_done, lsu_misaligned, lsu_buserr.
  - Timeout counter is cleared.
  - Reset asserted mid-access abandons the access; an ack arriving during or after reset is ignored.
- Byte order is little-endian: addr[1:0]=0 selects bits 7:0.
- State machine: IDLE, ACCESS, DONE.
- IDLE:
  - lsu_valid=1 captures is_store, bytes, sign_ext, addr and wdata into registers. Inputs may change after capture.
  - Alignment is legal when bytes=1; bytes=2 with addr[0]=0; or bytes=4 with addr[1:0]=0.
  - Any other lsu_bytes value is also illegal.
  - Illegal request: go to DONE with misaligned flag set. No memory request is issued and lsu_rdata is unchanged.
  - Legal request: go to ACCESS.
  - Next cycle drives mem_req=1, mem_addr, and mem_we/mem_wdata for stores.
- Store lane steering:
  - SB: mem_we = 4'b0001 << addr[1:0]; mem_wdata = wdata[7:0] replicated ×4.
  - SH: mem_we = 4'b0011 << addr[1:0]; mem_wdata = wdata[15:0] replicated ×2.
  - SW: mem_we = 4'b1111; mem_wdata = wdata.
- ACCESS:
  - mem_req and all mem_* outputs are held stable until mem_ack.
  - mem_ack=1: drop mem_req and mem_we. For loads, register the formatted mem_rdata into lsu_rdata. Go to DONE.
  - Load format: byte = rdata[8*a+7:8*a] and half = rdata[16*a1+15:16*a1], extended per sign_ext; word passes through unmodified.
  - No ack: the counter increments. When it reaches TIMEOUT_CYCLES, drop mem_req and go to DONE with buserr set; lsu_rdata is unchanged.
  - If ack and timeout occur in the same cycle, the ack wins.
- DONE:
  - lsu_done=1 for exactly one cycle, together with lsu_misaligned/lsu_buserr. Flags are 0 otherwise.
  - Return to IDLE.
  - Stores leave lsu_rdata unchanged. lsu_rdata holds until the next load completes.
- lsu_stall = lsu_valid & ~lsu_done (combinational).
- lsu_valid still high in IDLE after DONE is treated as a new request.
- mem_ack outside ACCESS is ignored.
- Latency, request seen at edge 0:
  - mem_req is high after edge 1.
  - Ack in the first ACCESS cycle gives lsu_done in the following cycle, a minimum of 3 cycles from request to done.
  - Misaligned requests give lsu_done one cycle after acceptance.

Test Plan:
- Load byte, addr=0x1003, sign_ext=1, mem_rdata=0x80AABBCC, ack after 2 cycles -> mem_addr=0x1000, mem_we=0, lsu_rdata=0xFFFFFF80, single lsu_done pulse, stall high until done.
- Load half, addr=0x2002, sign_ext=0, mem_rdata=0xF00D1234, zero-wait ack -> lsu_rdata=0x0000F00D; done 3 cycles after request.
- Store half, addr=0x3002, wdata=0x1234ABCD -> mem_we=4'b1100, mem_wdata=0xABCDABCD, held until ack; lsu_rdata unchanged.
- Word access at addr=0x4001 -> no mem_req, lsu_done with lsu_misaligned=1 next cycle. Half access at addr=0x4003 gives the same result. Byte access at 0x4003 is legal.
- No ack, TIMEOUT_CYCLES=4 -> mem_req high exactly 4 cycles, then lsu_done with lsu_buserr=1. A repeated run with ack on cycle 4 completes normally.
- rst_b low during ACCESS, with ack arriving in the reset cycle -> all outputs 0 and state IDLE; no lsu_done. A fresh request afterwards completes correctly.
